stall_sequencer: RTL

//  Multi-source, parametrised pipeline stall generator for the decode/hazard stage.
//  - Each of NUM_SRC hazard sources (load-use, mem busy, ...) requests an N-cycle stall.
//  - The block merges requests, holds stall high for the longest outstanding demand, and honours a flush.
//  - Out-of-range requests are flagged, saturated, and serviced.

---
 rtl/stall_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/stall_sequencer.sv
// Multi-source pipeline stall generator: merges N-cycle stall requests, holds stall
// for the longest outstanding demand, honours flush. Optional macro: STALL_PERF_EN.
module stall_sequencer #(
  parameter int NUM_SRC   = 2,
  parameter int CNT_W     = 2,
  parameter int MAX_STALL = 2,
  parameter int PERF_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*CNT_W-1:0] stall_req,
  input  logic                     flush,
  output logic                     stall,
  output logic                     busy,
  output logic [CNT_W-1:0]         remaining,
`ifdef STALL_PERF_EN
  output logic [PERF_W-1:0]        perf_count,
`endif
  output logic                     err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STALL);

  if (MAX_STALL > (2**CNT_W) - 1) begin : g_bad_max
    $error("stall_sequencer: MAX_STALL does not fit in CNT_W bits");
  end
  if (NUM_SRC < 1) begin : g_bad_src
    $error("stall_sequencer: NUM_SRC must be >= 1");
  end
  if (MAX_STALL < 1) begin : g_bad_min
    $error("stall_sequencer: MAX_STALL must be >= 1");
  end

  logic [CNT_W-1:0] req_max;
  logic             illegal;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] dec;
  logic [CNT_W-1:0] new_cnt;
  logic [CNT_W-1:0] remaining_next;

  always_comb begin
    req_max = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (stall_req[i*CNT_W +: CNT_W] > req_max)
        req_max = stall_req[i*CNT_W +: CNT_W];
    end
    illegal = (req_max > MAX_C);
    eff     = illegal ? MAX_C : req_max;
    // The request cycle itself is one of the N stall cycles, so only N-1 are owed.
    dec     = (remaining == '0) ? '0 : remaining - 1'b1;
    new_cnt = (eff == '0) ? '0 : eff - 1'b1;
    if (flush)
      remaining_next = '0;
    else
      remaining_next = (dec > new_cnt) ? dec : new_cnt;
    stall = rst & ~flush & ((remaining != '0) | (eff != '0));
  end

  assign busy = (remaining != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      remaining <= remaining_next;
      err       <= illegal;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst)
      perf_count <= '0;
    else if (stall && (perf_count != '1))
      perf_count <= perf_count + 1'b1;
  end
`endif

endmodule
